// File: rtl/pipe_valid_tracker_if.sv
// Hazard stall/flush interface between the hazard control unit and the valid tracker.
//   master : hazard control side, drives fetch_valid, ifid_write, pc_write and the
//            three flush strobes; observes pc_en and the per-stage valid bits.
//   slave  : tracker side, the reverse direction of the same signals.
interface pipe_valid_tracker_if;
   logic fetch_valid;   // IF stage holds a real instruction this cycle
   logic ifid_write;    // 1: IF/ID may load, 0: hold (stall)
   logic pc_write;      // 1: PC may advance
   logic ifid_flush;    // squash IF/ID
   logic idex_flush;    // squash ID/EX (bubble insert)
   logic exmem_flush;   // squash EX/MEM
   logic pc_en;         // PC register enable
   logic ifid_valid;
   logic idex_valid;
   logic exmem_valid;
   logic memwb_valid;   // high means an instruction retires this cycle

   modport master (
      output fetch_valid, ifid_write, pc_write, ifid_flush, idex_flush, exmem_flush,
      input  pc_en, ifid_valid, idex_valid, exmem_valid, memwb_valid
   );

   modport slave (
      input  fetch_valid, ifid_write, pc_write, ifid_flush, idex_flush, exmem_flush,
      output pc_en, ifid_valid, idex_valid, exmem_valid, memwb_valid
   );
endinterface

// File: rtl/pipe_valid_tracker.sv
// Consumer end of the hazard stall/flush interface.
// Tracks a valid bit per pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB), drives the PC
// enable, counts stall cycles, flush cycles and retirements with saturating counters, and
// raises sticky flags for a stall run that reaches MAX_STALL and for ifid_write != pc_write.
// Ports:
//   clk, rst       core clock; synchronous active-high reset
//   bus            pipe_valid_tracker_if.slave (control strobes in, pc_en and valids out)
//   stall_cycles   cycles with ifid_write == 0
//   flush_events   cycles with at least one flush strobe
//   retired        instructions retired (memwb_valid cycles)
//   stall_timeout  sticky: stall run reached MAX_STALL
//   protocol_err   sticky: ifid_write != pc_write seen
module pipe_valid_tracker #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned MAX_STALL = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_valid_tracker_if.slave  bus,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_events,
   output logic [CNT_W-1:0]     retired,
   output logic                 stall_timeout,
   output logic                 protocol_err
);

   localparam int unsigned RunW = $clog2(MAX_STALL + 1);
   localparam logic [RunW-1:0] RunTrip = RunW'(MAX_STALL - 1);
   localparam logic [RunW-1:0] RunMax  = RunW'(MAX_STALL);

   logic             ifid_valid_q;
   logic             idex_valid_q;
   logic             exmem_valid_q;
   logic             memwb_valid_q;
   logic [CNT_W-1:0] stall_cycles_q;
   logic [CNT_W-1:0] flush_events_q;
   logic [CNT_W-1:0] retired_q;
   logic [RunW-1:0]  run_q;
   logic             stall_timeout_q;
   logic             protocol_err_q;

   logic stall;
   logic any_flush;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   always_comb begin
      stall     = ~bus.ifid_write;
      any_flush = bus.ifid_flush | bus.idex_flush | bus.exmem_flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_valid_q    <= 1'b0;
         idex_valid_q    <= 1'b0;
         exmem_valid_q   <= 1'b0;
         memwb_valid_q   <= 1'b0;
         stall_cycles_q  <= '0;
         flush_events_q  <= '0;
         retired_q       <= '0;
         run_q           <= '0;
         stall_timeout_q <= 1'b0;
         protocol_err_q  <= 1'b0;
      end else begin
         // Flush beats stall beats advance.
         ifid_valid_q  <= bus.ifid_flush  ? 1'b0 :
                          bus.ifid_write  ? bus.fetch_valid : ifid_valid_q;
         // A stalled IF/ID leaves a bubble behind it in ID/EX.
         idex_valid_q  <= bus.idex_flush  ? 1'b0 :
                          bus.ifid_write  ? ifid_valid_q : 1'b0;
         exmem_valid_q <= bus.exmem_flush ? 1'b0 : idex_valid_q;
         memwb_valid_q <= exmem_valid_q;

         stall_cycles_q <= sat_inc(stall_cycles_q, stall);
         flush_events_q <= sat_inc(flush_events_q, any_flush);
         retired_q      <= sat_inc(retired_q, memwb_valid_q);

         // Watchdog: run_q counts consecutive stall edges; it is held at MAX_STALL so a
         // long stall cannot wrap it back into the non-tripped range.
         if (stall) begin
            if (run_q == RunTrip) begin
               stall_timeout_q <= 1'b1;
            end
            if (run_q != RunMax) begin
               run_q <= run_q + 1'b1;
            end
         end else begin
            run_q <= '0;
         end

         if (bus.ifid_write != bus.pc_write) begin
            protocol_err_q <= 1'b1;
         end
      end
   end

   // PC enable is combinational so the hazard unit's decision takes effect this cycle.
   assign bus.pc_en       = bus.pc_write & ~rst;
   assign bus.ifid_valid  = ifid_valid_q;
   assign bus.idex_valid  = idex_valid_q;
   assign bus.exmem_valid = exmem_valid_q;
   assign bus.memwb_valid = memwb_valid_q;

   assign stall_cycles  = stall_cycles_q;
   assign flush_events  = flush_events_q;
   assign retired       = retired_q;
   assign stall_timeout = stall_timeout_q;
   assign protocol_err  = protocol_err_q;

endmodule

// File: tb/tb_pipe_valid_tracker.sv
// Directed bench for pipe_valid_tracker: a 32-bit-counter instance and a 4-bit-counter
// instance see identical stimulus; the narrow one exercises counter saturation.
module tb_pipe_valid_tracker;

   logic clk;
   logic rst;

   logic [31:0] sc32, fe32, rt32;
   logic        to32, pe32;
   logic [3:0]  sc4, fe4, rt4;
   logic        to4, pe4;

   int checks = 0;
   int errors = 0;

   pipe_valid_tracker_if b32 ();
   pipe_valid_tracker_if b4 ();

   pipe_valid_tracker #(.CNT_W(32), .MAX_STALL(4)) dut32 (
      .clk           (clk),
      .rst           (rst),
      .bus           (b32.slave),
      .stall_cycles  (sc32),
      .flush_events  (fe32),
      .retired       (rt32),
      .stall_timeout (to32),
      .protocol_err  (pe32)
   );

   pipe_valid_tracker #(.CNT_W(4), .MAX_STALL(4)) dut4 (
      .clk           (clk),
      .rst           (rst),
      .bus           (b4.slave),
      .stall_cycles  (sc4),
      .flush_events  (fe4),
      .retired       (rt4),
      .stall_timeout (to4),
      .protocol_err  (pe4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {ifid, idex, exmem, memwb}
   function automatic logic [3:0] v32();
      return {b32.ifid_valid, b32.idex_valid, b32.exmem_valid, b32.memwb_valid};
   endfunction

   task automatic set_in(input logic fv, input logic iw, input logic pw,
                         input logic f1, input logic f2, input logic f3);
      b32.fetch_valid = fv; b32.ifid_write = iw; b32.pc_write = pw;
      b32.ifid_flush  = f1; b32.idex_flush = f2; b32.exmem_flush = f3;
      b4.fetch_valid  = fv; b4.ifid_write  = iw; b4.pc_write  = pw;
      b4.ifid_flush   = f1; b4.idex_flush  = f2; b4.exmem_flush  = f3;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      checks++;
      if (b32.pc_en !== 1'b0) begin
         errors++; $display("FAIL reset_pc_en: got %b expected 0", b32.pc_en);
      end
      tick();
      tick();
      checks++;
      if (v32() !== 4'b0000) begin
         errors++; $display("FAIL reset_valids: got %b expected 0000", v32());
      end
      checks++;
      if ({sc32, fe32, rt32} !== 96'd0) begin
         errors++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", sc32, fe32, rt32);
      end
      checks++;
      if ({to32, pe32} !== 2'b00) begin
         errors++; $display("FAIL reset_flags: got %b expected 00", {to32, pe32});
      end
   endtask

   task automatic test_flow();
      logic [3:0] exp_v;
      rst = 1'b0;
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (b32.pc_en !== 1'b1) begin
         errors++; $display("FAIL flow_pc_en: got %b expected 1", b32.pc_en);
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         exp_v = {k >= 1, k >= 2, k >= 3, k >= 4};
         checks++;
         if (v32() !== exp_v) begin
            errors++; $display("FAIL flow_valids_edge%0d: got %b expected %b", k, v32(), exp_v);
         end
      end
      checks++;
      if (rt32 !== 32'd6) begin
         errors++; $display("FAIL flow_retired: got %0d expected 6", rt32);
      end
      checks++;
      if (sc32 !== 32'd0 || fe32 !== 32'd0) begin
         errors++; $display("FAIL flow_stall_flush: got %0d/%0d expected 0/0", sc32, fe32);
      end
   endtask

   task automatic test_stall_flush();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (b32.pc_en !== 1'b0) begin
         errors++; $display("FAIL stall_pc_en: got %b expected 0", b32.pc_en);
      end
      tick();
      checks++;
      if (v32() !== 4'b1011) begin
         errors++; $display("FAIL stall_valids: got %b expected 1011", v32());
      end
      checks++;
      if (sc32 !== 32'd1 || fe32 !== 32'd1 || rt32 !== 32'd7) begin
         errors++; $display("FAIL stall_counts: got %0d/%0d/%0d expected 1/1/7", sc32, fe32, rt32);
      end
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (v32() !== 4'b1101 || rt32 !== 32'd8) begin
         errors++; $display("FAIL stall_release1: got %b/%0d expected 1101/8", v32(), rt32);
      end
      tick();
      checks++;
      if (v32() !== 4'b1110 || rt32 !== 32'd9) begin
         errors++; $display("FAIL stall_release2: got %b/%0d expected 1110/9", v32(), rt32);
      end
      tick();
      tick();
      checks++;
      if (v32() !== 4'b1111 || rt32 !== 32'd10) begin
         errors++; $display("FAIL stall_release4: got %b/%0d expected 1111/10", v32(), rt32);
      end
   endtask

   task automatic test_flush_all();
      logic [3:0] exp_v [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      checks++;
      if (v32() !== 4'b0001 || fe32 !== 32'd2 || rt32 !== 32'd11) begin
         errors++; $display("FAIL flushall: got %b/%0d/%0d expected 0001/2/11", v32(), fe32, rt32);
      end
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (v32() !== exp_v[k] || rt32 !== 32'd12) begin
            errors++;
            $display("FAIL flushall_refill%0d: got %b/%0d expected %b/12", k, v32(), rt32, exp_v[k]);
         end
      end
      tick();
      checks++;
      if (rt32 !== 32'd13 || fe32 !== 32'd2) begin
         errors++; $display("FAIL flushall_resume: got %0d/%0d expected 13/2", rt32, fe32);
      end
   endtask

   task automatic test_timeout();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (to32 !== 1'b0) begin
            errors++; $display("FAIL timeout_short%0d: got %b expected 0", k, to32);
         end
      end
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (to32 !== 1'b0) begin
         errors++; $display("FAIL timeout_after_advance: got %b expected 0", to32);
      end
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (to32 !== (k == 4)) begin
            errors++; $display("FAIL timeout_run%0d: got %b expected %b", k, to32, k == 4);
         end
      end
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checks++;
      if (to32 !== 1'b1 || sc32 !== 32'd7 || pe32 !== 1'b0) begin
         errors++; $display("FAIL timeout_sticky: got %b/%0d/%b expected 1/7/0", to32, sc32, pe32);
      end
   endtask

   task automatic test_protocol();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (b32.pc_en !== 1'b0 || pe32 !== 1'b0) begin
         errors++; $display("FAIL proto_before: got %b/%b expected 0/0", b32.pc_en, pe32);
      end
      tick();
      checks++;
      if (pe32 !== 1'b1 || v32() !== 4'b1000) begin
         errors++; $display("FAIL proto_set: got %b/%b expected 1/1000", pe32, v32());
      end
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checks++;
      if (pe32 !== 1'b1) begin
         errors++; $display("FAIL proto_sticky: got %b expected 1", pe32);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (pe32 !== 1'b0) begin
         errors++; $display("FAIL proto_reset: got %b expected 0", pe32);
      end
   endtask

   task automatic test_saturate();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 14) begin
            checks++;
            if (sc4 !== 4'd14) begin
               errors++; $display("FAIL sat_edge14: got %0d expected 14", sc4);
            end
         end
      end
      checks++;
      if (sc4 !== 4'd15 || sc32 !== 32'd20) begin
         errors++; $display("FAIL sat_final: got %0d/%0d expected 15/20", sc4, sc32);
      end
      checks++;
      if (to4 !== 1'b1 || pe4 !== 1'b0) begin
         errors++; $display("FAIL sat_flags: got %b/%b expected 1/0", to4, pe4);
      end
   endtask

   task automatic test_mid_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      checks++;
      if (v32() !== 4'b1110) begin
         errors++; $display("FAIL midrst_fill: got %b expected 1110", v32());
      end
      rst = 1'b1;
      tick();
      checks++;
      if (v32() !== 4'b0000) begin
         errors++; $display("FAIL midrst_clear: got %b expected 0000", v32());
      end
      rst = 1'b0;
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if (v32() !== 4'b0000 || rt32 !== 32'd0) begin
         errors++; $display("FAIL midrst_no_retire: got %b/%0d expected 0000/0", v32(), rt32);
      end
   endtask

   initial begin
      test_reset();
      test_flow();
      test_stall_flush();
      test_flush_all();
      test_timeout();
      test_protocol();
      test_saturate();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
